rn_inject_buffer: RTL and testbench



---
 rtl/rn_inject_buffer.sv | 85 ++++++++
 tb/tb_rn_inject_buffer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/rn_inject_buffer.sv
// rn_inject_buffer: credit-controlled local-injection FIFO with look-ahead XY port for an RN router
//   clk, rst                    : clock, synchronous active-high reset
//   dev_flit_v_i/dev_flit_i     : device push
//   dev_credit_o                : one-cycle credit return pulse, one cycle after each pop
//   node_id_x_i/node_id_y_i     : static router coordinates
//   flit_v_o/flit_o             : head entry valid and flit
//   flit_look_ahead_routing_o   : first-hop port toward (x=1, y=0), computed at push time
//   flit_pop_i                  : router consumed the head flit
//   count_o                     : occupancy 0..DEPTH
//   overflow_err_o              : sticky, set by a push while full
module rn_inject_buffer #(
  parameter type flit_payload_t = logic [255:0],
  parameter type io_port_t = logic [2:0],
  parameter int DEPTH = 4,
  parameter int NodeID_X_Width = 4,
  parameter int NodeID_Y_Width = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       dev_flit_v_i,
  input  flit_payload_t              dev_flit_i,
  output logic                       dev_credit_o,
  input  logic [NodeID_X_Width-1:0]  node_id_x_i,
  input  logic [NodeID_Y_Width-1:0]  node_id_y_i,
  output logic                       flit_v_o,
  output flit_payload_t              flit_o,
  output io_port_t                   flit_look_ahead_routing_o,
  input  logic                       flit_pop_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       overflow_err_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam io_port_t PORT_LOCAL = io_port_t'(0);
  localparam io_port_t PORT_XP = io_port_t'(1);
  localparam io_port_t PORT_XM = io_port_t'(2);
  localparam io_port_t PORT_YM = io_port_t'(4);
  flit_payload_t flit_mem_q [DEPTH];
  io_port_t port_mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic credit_q, credit_d, ovf_q, ovf_d;
  logic push, pop;
  io_port_t la_port;
  // fullness uses the pre-pop count, so a push while full is rejected even with a pop
  always_comb begin
    push = dev_flit_v_i && (count_q != CW'(DEPTH));
    pop = (count_q != '0) && flit_pop_i;
    la_port = (node_id_x_i == '0) ? PORT_XP :
              (node_id_x_i > NodeID_X_Width'(1)) ? PORT_XM :
              (node_id_y_i != '0) ? PORT_YM : PORT_LOCAL;
    wr_d = push ? wr_q + AW'(1) : wr_q;
    rd_d = pop ? rd_q + AW'(1) : rd_q;
    count_d = count_q + CW'(push) - CW'(pop);
    credit_d = pop;
    ovf_d = ovf_q || (dev_flit_v_i && !push);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
      credit_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
      credit_q <= credit_d;
      ovf_q <= ovf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      flit_mem_q[wr_q] <= dev_flit_i;
      port_mem_q[wr_q] <= la_port;
    end
  end
  assign flit_v_o = count_q != '0;
  assign flit_o = flit_mem_q[rd_q];
  assign flit_look_ahead_routing_o = port_mem_q[rd_q];
  assign count_o = count_q;
  assign dev_credit_o = credit_q;
  assign overflow_err_o = ovf_q;
endmodule

// File: tb/tb_rn_inject_buffer.sv
// tb_rn_inject_buffer: directed self-checking bench for rn_inject_buffer
module tb_rn_inject_buffer;
  localparam logic [2:0] P_LOCAL = 3'd0;
  localparam logic [2:0] P_XP = 3'd1;
  localparam logic [2:0] P_XM = 3'd2;
  localparam logic [2:0] P_YM = 3'd4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic dev_flit_v_i = 1'b0;
  logic [255:0] dev_flit_i = '0;
  logic dev_credit_o;
  logic [3:0] node_id_x_i = '0;
  logic [3:0] node_id_y_i = '0;
  logic flit_v_o;
  logic [255:0] flit_o;
  logic [2:0] flit_look_ahead_routing_o;
  logic flit_pop_i = 1'b0;
  logic [2:0] count_o;
  logic overflow_err_o;
  int tests = 0;
  int fails = 0;
  rn_inject_buffer dut (
    .clk(clk),
    .rst(rst),
    .dev_flit_v_i(dev_flit_v_i),
    .dev_flit_i(dev_flit_i),
    .dev_credit_o(dev_credit_o),
    .node_id_x_i(node_id_x_i),
    .node_id_y_i(node_id_y_i),
    .flit_v_o(flit_v_o),
    .flit_o(flit_o),
    .flit_look_ahead_routing_o(flit_look_ahead_routing_o),
    .flit_pop_i(flit_pop_i),
    .count_o(count_o),
    .overflow_err_o(overflow_err_o)
  );
  always #5 clk = ~clk;
  function automatic logic [255:0] mk(input int i);
    return {8{32'hF1170000 + 32'(i)}};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset(input logic [3:0] x, input logic [3:0] y);
    dev_flit_v_i = 1'b0;
    flit_pop_i = 1'b0;
    node_id_x_i = x;
    node_id_y_i = y;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask
  task automatic test_reset();
    do_reset(4'd0, 4'd0);
    tests++;
    if (flit_v_o !== 1'b0 || count_o !== 3'd0 || dev_credit_o !== 1'b0 || overflow_err_o !== 1'b0) begin
      fails++;
      $display("FAIL reset: v=%b cnt=%0d cr=%b ovf=%b, required 0 0 0 0", flit_v_o, count_o, dev_credit_o, overflow_err_o);
    end
  endtask
  task automatic test_basic();
    do_reset(4'd0, 4'd0);
    dev_flit_v_i = 1'b1;
    dev_flit_i = mk(100);
    step();
    tests++;
    if (flit_v_o !== 1'b1 || flit_o !== mk(100) || flit_look_ahead_routing_o !== P_XP || count_o !== 3'd1) begin
      fails++;
      $display("FAIL basic_first: v=%b flit=%h port=%0d cnt=%0d, required 1 %h %0d 1", flit_v_o, flit_o[31:0], flit_look_ahead_routing_o, count_o, mk(100) & 256'hFFFFFFFF, P_XP);
    end
    dev_flit_i = mk(101);
    step();
    dev_flit_v_i = 1'b0;
    tests++;
    if (count_o !== 3'd2 || flit_o !== mk(100)) begin
      fails++;
      $display("FAIL basic_second: cnt=%0d flit=%h, required 2 A", count_o, flit_o[31:0]);
    end
    step();
    tests++;
    if (flit_o !== mk(100) || count_o !== 3'd2 || dev_credit_o !== 1'b0) begin
      fails++;
      $display("FAIL basic_hold: flit=%h cnt=%0d cr=%b, required A 2 0", flit_o[31:0], count_o, dev_credit_o);
    end
  endtask
  task automatic test_drain_in_order();
    do_reset(4'd1, 4'd2);
    for (int i = 0; i < 4; i++) begin
      dev_flit_v_i = 1'b1;
      dev_flit_i = mk(200 + i);
      step();
    end
    dev_flit_v_i = 1'b0;
    tests++;
    if (count_o !== 3'd4) begin
      fails++;
      $display("FAIL drain_full: cnt=%0d, required 4", count_o);
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (flit_v_o !== 1'b1 || flit_o !== mk(200 + i) || flit_look_ahead_routing_o !== P_YM || count_o !== 3'(4 - i)) begin
        fails++;
        $display("FAIL drain_head%0d: v=%b flit=%h port=%0d cnt=%0d, required 1 %0d %0d %0d", i, flit_v_o, flit_o[31:0], flit_look_ahead_routing_o, count_o, 200 + i, P_YM, 4 - i);
      end
      flit_pop_i = 1'b1;
      step();
      tests++;
      if (dev_credit_o !== 1'b1) begin
        fails++;
        $display("FAIL drain_credit%0d: cr=%b, required 1", i, dev_credit_o);
      end
    end
    flit_pop_i = 1'b0;
    tests++;
    if (flit_v_o !== 1'b0 || count_o !== 3'd0) begin
      fails++;
      $display("FAIL drain_empty: v=%b cnt=%0d, required 0 0", flit_v_o, count_o);
    end
    step();
    tests++;
    if (dev_credit_o !== 1'b0) begin
      fails++;
      $display("FAIL drain_credit_end: cr=%b, required 0", dev_credit_o);
    end
  endtask
  task automatic test_overflow();
    do_reset(4'd3, 4'd0);
    for (int i = 0; i < 5; i++) begin
      dev_flit_v_i = 1'b1;
      dev_flit_i = mk(300 + i);
      step();
      if (i == 3) begin
        tests++;
        if (count_o !== 3'd4 || overflow_err_o !== 1'b0) begin
          fails++;
          $display("FAIL ovf_pre: cnt=%0d ovf=%b, required 4 0", count_o, overflow_err_o);
        end
      end
    end
    dev_flit_v_i = 1'b0;
    tests++;
    if (count_o !== 3'd4 || overflow_err_o !== 1'b1) begin
      fails++;
      $display("FAIL ovf_set: cnt=%0d ovf=%b, required 4 1", count_o, overflow_err_o);
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (flit_o !== mk(300 + i) || flit_look_ahead_routing_o !== P_XM || overflow_err_o !== 1'b1) begin
        fails++;
        $display("FAIL ovf_drain%0d: flit=%h port=%0d ovf=%b, required %0d %0d 1", i, flit_o[31:0], flit_look_ahead_routing_o, overflow_err_o, 300 + i, P_XM);
      end
      flit_pop_i = 1'b1;
      step();
    end
    flit_pop_i = 1'b0;
    tests++;
    if (flit_v_o !== 1'b0 || count_o !== 3'd0 || overflow_err_o !== 1'b1) begin
      fails++;
      $display("FAIL ovf_end: v=%b cnt=%0d ovf=%b, required 0 0 1", flit_v_o, count_o, overflow_err_o);
    end
  endtask
  task automatic test_back_to_back();
    int credits;
    do_reset(4'd1, 4'd0);
    credits = 0;
    dev_flit_v_i = 1'b1;
    dev_flit_i = mk(400);
    step();
    for (int i = 0; i < 20; i++) begin
      tests++;
      if (flit_o !== mk(400 + i) || flit_look_ahead_routing_o !== P_LOCAL || count_o !== 3'd1) begin
        fails++;
        $display("FAIL b2b_%0d: flit=%h port=%0d cnt=%0d, required %0d %0d 1", i, flit_o[31:0], flit_look_ahead_routing_o, count_o, 400 + i, P_LOCAL);
      end
      dev_flit_i = mk(401 + i);
      flit_pop_i = 1'b1;
      step();
      if (dev_credit_o === 1'b1) credits++;
    end
    dev_flit_v_i = 1'b0;
    flit_pop_i = 1'b0;
    tests++;
    if (credits != 20 || count_o !== 3'd1 || flit_o !== mk(420)) begin
      fails++;
      $display("FAIL b2b_total: credits=%0d cnt=%0d flit=%h, required 20 1 %0d", credits, count_o, flit_o[31:0], 420);
    end
  endtask
  task automatic test_empty_pop_and_reset();
    do_reset(4'd0, 4'd0);
    step();
    flit_pop_i = 1'b1;
    step();
    flit_pop_i = 1'b0;
    tests++;
    if (dev_credit_o !== 1'b0 || count_o !== 3'd0 || flit_v_o !== 1'b0) begin
      fails++;
      $display("FAIL empty_pop: cr=%b cnt=%0d v=%b, required 0 0 0", dev_credit_o, count_o, flit_v_o);
    end
    for (int i = 0; i < 3; i++) begin
      dev_flit_v_i = 1'b1;
      dev_flit_i = mk(500 + i);
      step();
    end
    dev_flit_v_i = 1'b0;
    tests++;
    if (count_o !== 3'd3) begin
      fails++;
      $display("FAIL rst_pre: cnt=%0d, required 3", count_o);
    end
    rst = 1'b1;
    flit_pop_i = 1'b1;
    step();
    rst = 1'b0;
    flit_pop_i = 1'b0;
    tests++;
    if (flit_v_o !== 1'b0 || count_o !== 3'd0 || dev_credit_o !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid: v=%b cnt=%0d cr=%b, required 0 0 0", flit_v_o, count_o, dev_credit_o);
    end
    step();
    tests++;
    if (dev_credit_o !== 1'b0 || flit_v_o !== 1'b0) begin
      fails++;
      $display("FAIL rst_after: cr=%b v=%b, required 0 0", dev_credit_o, flit_v_o);
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_drain_in_order();
    test_overflow();
    test_back_to_back();
    test_empty_pop_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
